// File: rtl/ndata_to_axi_packed.sv
// ----------------------------------------------------------------------------
// ndata_to_axi_packed
//
// Packs an NUM_ELEMENTS-wide ndata stream of typed elements into a
// 64*NUM_ELEMENTS-bit AXI4-Stream word. Each input element sits in a 64-bit
// slot and carries a W-bit value in its low bits (W = 8/16/32/64). P = 64/W
// consecutive input beats are packed into one output word; a beat with
// in_last closes the word early, leaving the unfilled slots at zero.
//
// Element type encoding (in_type_data):
//   3'd0 = 8-bit, 3'd1 = 16-bit, 3'd2 = 32-bit, 3'd3 = 64-bit, others illegal.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_type_*         type handshake; consumed with the last beat of a stream
//   in_valid/ready    input beat handshake (ready is combinational)
//   in_data           NUM_ELEMENTS x 64-bit element slots
//   in_keep           one keep bit per element
//   in_last           last beat of the stream
//   out_t*            AXI4-Stream master (registered)
//   words_out         wrapping count of output words produced since reset
// ----------------------------------------------------------------------------

module ndata_to_axi_packed_chk (
    input logic clk,
    input logic rst_n,
    input logic type_valid,
    input logic type_ok
);
    // Abort simulation when an unsupported element type is offered.
    always @(posedge clk) begin
        if (rst_n && type_valid) begin
            assert (type_ok)
            else $fatal(1, "ndata_to_axi_packed: unsupported element type");
        end
    end
endmodule

module ndata_to_axi_packed #(
    parameter int NUM_ELEMENTS = 8,
    localparam int AXI_WIDTH = 64 * NUM_ELEMENTS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_type_valid,
    output logic                               in_type_ready,
    input  logic [2:0]                         in_type_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_ELEMENTS-1:0][63:0]      in_data,
    input  logic [NUM_ELEMENTS-1:0]            in_keep,
    input  logic                               in_last,
    output logic                               out_tvalid,
    input  logic                               out_tready,
    output logic [AXI_WIDTH-1:0]               out_tdata,
    output logic [AXI_WIDTH/8-1:0]             out_tkeep,
    output logic                               out_tlast,
    output logic [31:0]                        words_out
);
    localparam int NE = NUM_ELEMENTS;

    localparam logic [2:0] TYPE_W8  = 3'd0;
    localparam logic [2:0] TYPE_W16 = 3'd1;
    localparam logic [2:0] TYPE_W32 = 3'd2;
    localparam logic [2:0] TYPE_W64 = 3'd3;

    logic [AXI_WIDTH-1:0]   data_r;
    logic [AXI_WIDTH-1:0]   data_s;
    logic [AXI_WIDTH/8-1:0] keep_r;
    logic [AXI_WIDTH/8-1:0] keep_s;
    logic                   valid_r;
    logic                   last_r;
    logic [2:0]             slot_r;
    logic [2:0]             last_slot_s;
    logic                   type_ok_s;
    logic [31:0]            words_r;
    logic                   accept_s;
    logic                   complete_s;

    // Index of the final slot for the current element width (P-1).
    always_comb begin
        last_slot_s = 3'd0;
        type_ok_s   = 1'b1;
        case (in_type_data)
            TYPE_W8:  last_slot_s = 3'd7;
            TYPE_W16: last_slot_s = 3'd3;
            TYPE_W32: last_slot_s = 3'd1;
            TYPE_W64: last_slot_s = 3'd0;
            default: begin
                last_slot_s = 3'd0;
                type_ok_s   = 1'b0;
            end
        endcase
    end

    // Handshakes: a pending word blocks input unless it drains this cycle.
    assign in_ready      = in_type_valid && (!valid_r || out_tready);
    assign accept_s      = in_valid && in_ready;
    assign in_type_ready = accept_s && in_last;
    assign complete_s    = (slot_r == last_slot_s) || in_last;

    // Next staging contents: slot 0 starts from a cleared word, so slots not
    // reached before the word closes stay zero in both data and keep.
    always_comb begin
        data_s = (slot_r == 3'd0) ? '0 : data_r;
        keep_s = (slot_r == 3'd0) ? '0 : keep_r;
        case (in_type_data)
            TYPE_W8: begin
                for (int s = 0; s < 8; s++) begin
                    for (int i = 0; i < NE; i++) begin
                        data_s[(s*NE+i)*8 +: 8] = (slot_r == 3'(s)) ? in_data[i][7:0]
                                                                     : data_s[(s*NE+i)*8 +: 8];
                        keep_s[s*NE+i] = (slot_r == 3'(s)) ? in_keep[i] : keep_s[s*NE+i];
                    end
                end
            end
            TYPE_W16: begin
                for (int s = 0; s < 4; s++) begin
                    for (int i = 0; i < NE; i++) begin
                        data_s[(s*NE+i)*16 +: 16] = (slot_r == 3'(s)) ? in_data[i][15:0]
                                                                       : data_s[(s*NE+i)*16 +: 16];
                        keep_s[(s*NE+i)*2 +: 2] = (slot_r == 3'(s)) ? {2{in_keep[i]}}
                                                                     : keep_s[(s*NE+i)*2 +: 2];
                    end
                end
            end
            TYPE_W32: begin
                for (int s = 0; s < 2; s++) begin
                    for (int i = 0; i < NE; i++) begin
                        data_s[(s*NE+i)*32 +: 32] = (slot_r == 3'(s)) ? in_data[i][31:0]
                                                                       : data_s[(s*NE+i)*32 +: 32];
                        keep_s[(s*NE+i)*4 +: 4] = (slot_r == 3'(s)) ? {4{in_keep[i]}}
                                                                     : keep_s[(s*NE+i)*4 +: 4];
                    end
                end
            end
            TYPE_W64: begin
                for (int i = 0; i < NE; i++) begin
                    data_s[i*64 +: 64] = in_data[i];
                    keep_s[i*8 +: 8]   = {8{in_keep[i]}};
                end
            end
            default: begin
                data_s = data_r;
                keep_s = keep_r;
            end
        endcase
    end

    // Staging/output register, slot counter and word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r  <= '0;
            keep_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            slot_r  <= 3'd0;
            words_r <= 32'd0;
        end else if (accept_s) begin
            data_r <= data_s;
            keep_r <= keep_s;
            if (complete_s) begin
                valid_r <= 1'b1;
                last_r  <= in_last;
                slot_r  <= 3'd0;
                words_r <= words_r + 32'd1;
            end else begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
                slot_r  <= slot_r + 3'd1;
            end
        end else if (valid_r && out_tready) begin
            valid_r <= 1'b0;
        end
    end

    assign out_tvalid = valid_r;
    assign out_tdata  = data_r;
    assign out_tkeep  = keep_r;
    assign out_tlast  = last_r;
    assign words_out  = words_r;

    ndata_to_axi_packed_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .type_valid (in_type_valid),
        .type_ok    (type_ok_s)
    );

endmodule

// File: tb/tb_ndata_to_axi_packed.sv
// ----------------------------------------------------------------------------
// Testbench for ndata_to_axi_packed (NUM_ELEMENTS = 8, 512-bit output).
// Stimulus pushes expected words into a scoreboard queue; a monitor process
// pops and compares each word the DUT transfers.
// ----------------------------------------------------------------------------
module tb_ndata_to_axi_packed;
    localparam int NE = 8;
    localparam int AW = 64 * NE;
    localparam int KW = AW / 8;

    typedef logic [NE-1:0][63:0] beat_t;
    typedef logic [NE-1:0]       keep_t;
    typedef struct packed {
        logic [AW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } word_t;

    logic          clk;
    logic          rst_n;
    logic          in_type_valid;
    logic          in_type_ready;
    logic [2:0]    in_type_data;
    logic          in_valid;
    logic          in_ready;
    beat_t         in_data;
    keep_t         in_keep;
    logic          in_last;
    logic          out_tvalid;
    logic          out_tready;
    logic [AW-1:0] out_tdata;
    logic [KW-1:0] out_tkeep;
    logic          out_tlast;
    logic [31:0]   words_out;

    int    checks = 0;
    int    failures = 0;
    int    exp_words = 0;
    int    cyc = 0;
    logic  ready_force;
    logic  rand_ready;
    word_t sb[$];

    ndata_to_axi_packed #(.NUM_ELEMENTS(NE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_type_valid (in_type_valid),
        .in_type_ready (in_type_ready),
        .in_type_data  (in_type_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_keep       (in_keep),
        .in_last       (in_last),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .out_tdata     (out_tdata),
        .out_tkeep     (out_tkeep),
        .out_tlast     (out_tlast),
        .words_out     (words_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_wide(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] code_of(input int w);
        case (w)
            8:       return 3'd0;
            16:      return 3'd1;
            32:      return 3'd2;
            default: return 3'd3;
        endcase
    endfunction

    task automatic push_word(input word_t w);
        sb.push_back(w);
        exp_words++;
    endtask

    // Reference packing of one stream, bit by bit.
    task automatic model_stream(input int w, input beat_t bd[$], input keep_t bk[$]);
        word_t cur;
        int    slot;
        cur  = '0;
        slot = 0;
        for (int k = 0; k < bd.size(); k++) begin
            for (int i = 0; i < NE; i++) begin
                for (int b = 0; b < w; b++) cur.data[(slot*NE+i)*w + b] = bd[k][i][b];
                for (int y = 0; y < w/8; y++) cur.keep[(slot*NE+i)*(w/8) + y] = bk[k][i];
            end
            slot++;
            if (slot == 64/w || k == bd.size()-1) begin
                cur.last = (k == bd.size()-1);
                push_word(cur);
                cur  = '0;
                slot = 0;
            end
        end
    endtask

    // Present one beat (entered and left #1 after a rising edge).
    task automatic send_beat(input beat_t d, input keep_t k, input logic l, input int gap);
        int   budget;
        logic acc;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        budget   = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) check_val("type_ready_on_accept", 32'(in_type_ready), 32'(l));
            else     check_val("type_ready_idle", 32'(in_type_ready), 32'd0);
            @(posedge clk); #1;
            budget++;
        end while (!acc && budget < 300);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout: actual=not accepted required=accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int w, input beat_t bd[$], input keep_t bk[$], input int maxgap);
        in_type_data  = code_of(w);
        in_type_valid = 1'b1;
        model_stream(w, bd, bk);
        for (int k = 0; k < bd.size(); k++)
            send_beat(bd[k], bk[k], k == bd.size()-1, $urandom_range(0, maxgap));
        in_type_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_tvalid) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("drain_empty", 32'(sb.size() == 0 && !out_tvalid), 32'd1);
    endtask

    task automatic monitor_loop();
        word_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_tvalid && out_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: actual=%0h required=none", out_tdata);
                end else begin
                    e = sb.pop_front();
                    check_wide("word_tdata", out_tdata, e.data);
                    check_wide("word_tkeep", AW'(out_tkeep), AW'(e.keep));
                    check_val("word_tlast", 32'(out_tlast), 32'(e.last));
                end
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk); #2;
            out_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    endtask

    task automatic run_tests();
        word_t e;
        beat_t d;
        beat_t bd[$];
        keep_t bk[$];
        int    t0;

        // 8-bit packing: bytes 0..63 in order.
        in_type_data  = code_of(8);
        in_type_valid = 1'b1;
        e = '0;
        for (int j = 0; j < 64; j++) e.data[j*8 +: 8] = 8'(j);
        e.keep = '1;
        e.last = 1'b1;
        push_word(e);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NE; i++) d[i] = 64'hFFFF_FFFF_FFFF_FF00 | 64'(k*8+i);
            send_beat(d, 8'hFF, k == 7, 0);
            if (k < 7) check_val("t1_no_early_valid", 32'(out_tvalid), 32'd0);
            else       check_val("t1_valid_latency", 32'(out_tvalid), 32'd1);
        end
        in_type_valid = 1'b0;
        drain();
        check_val("t1_words_out", words_out, 32'd1);

        // 32-bit partial flush.
        in_type_data  = code_of(32);
        in_type_valid = 1'b1;
        e = '0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NE; i++) e.data[(s*NE+i)*32 +: 32] = 32'hA000_0000 + 32'(s*256 + i);
        e.keep = '1;
        e.last = 1'b0;
        push_word(e);
        e = '0;
        for (int i = 0; i < NE; i++) e.data[i*32 +: 32] = 32'hA000_0000 + 32'(2*256 + i);
        e.keep = 64'h0000_0000_FFFF_FFFF;
        e.last = 1'b1;
        push_word(e);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NE; i++) d[i] = {32'hDEAD_BEEF, 32'hA000_0000 + 32'(k*256 + i)};
            send_beat(d, 8'hFF, k == 2, 0);
        end
        in_type_valid = 1'b0;
        drain();
        check_val("t2_words_out", words_out, 32'd3);

        // Backpressure with 16-bit elements, 10 beats.
        bd.delete();
        bk.delete();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NE; i++) d[i] = {$urandom, $urandom};
            bd.push_back(d);
            bk.push_back(keep_t'($urandom));
        end
        in_type_data  = code_of(16);
        in_type_valid = 1'b1;
        model_stream(16, bd, bk);
        ready_force = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) send_beat(bd[k], bk[k], 1'b0, 0);
        check_val("bp_word_pending", 32'(out_tvalid), 32'd1);
        in_data  = bd[4];
        in_keep  = bk[4];
        in_last  = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("bp_in_ready_stalled", 32'(in_ready), 32'd0);
            check_val("bp_tvalid_held", 32'(out_tvalid), 32'd1);
            @(posedge clk); #1;
        end
        ready_force = 1'b1;
        t0 = cyc;
        for (int k = 4; k < 10; k++) send_beat(bd[k], bk[k], k == 9, 0);
        check_val("bp_throughput_cycles", 32'(cyc - t0), 32'd6);
        in_type_valid = 1'b0;
        drain();
        check_val("bp_words_out", words_out, 32'd6);

        // Type gating: no acceptance while in_type_valid is low.
        in_type_data = code_of(64);
        in_data      = '1;
        in_keep      = '1;
        in_last      = 1'b1;
        in_valid     = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("gate_in_ready", 32'(in_ready), 32'd0);
            check_val("gate_type_ready", 32'(in_type_ready), 32'd0);
            check_val("gate_tvalid", 32'(out_tvalid), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // 64-bit pass-through, back-to-back single-beat streams.
        in_type_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NE; i++) d[i] = {32'(n), 32'hC0DE_0000 + 32'(i)};
            e      = '0;
            e.data = d;
            e.keep = 64'h0000_0000_FFFF_FFFF;
            e.last = 1'b1;
            push_word(e);
            send_beat(d, 8'b0000_1111, 1'b1, 0);
        end
        in_type_valid = 1'b0;
        drain();
        check_val("p64_words_out", words_out, 32'd9);

        // Reset mid-word, then a fresh 8-bit stream.
        in_type_data  = code_of(8);
        in_type_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NE; i++) d[i] = 64'h5A + 64'(k*8+i);
            send_beat(d, 8'hFF, 1'b0, 0);
        end
        rst_n         = 1'b0;
        in_type_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("rst_tvalid", 32'(out_tvalid), 32'd0);
        check_val("rst_tlast", 32'(out_tlast), 32'd0);
        check_wide("rst_tdata", out_tdata, '0);
        check_wide("rst_tkeep", AW'(out_tkeep), '0);
        check_val("rst_words_out", words_out, 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        exp_words = 0;
        bd.delete();
        bk.delete();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NE; i++) d[i] = {$urandom, $urandom};
            bd.push_back(d);
            bk.push_back(keep_t'($urandom));
        end
        send_stream(8, bd, bk, 0);
        drain();
        check_val("rst_restart_words_out", words_out, 32'd1);

        // Randomised stress.
        rand_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            int w;
            int len;
            w   = 8 << $urandom_range(0, 3);
            len = $urandom_range(1, 40);
            bd.delete();
            bk.delete();
            for (int k = 0; k < len; k++) begin
                for (int i = 0; i < NE; i++) d[i] = {$urandom, $urandom};
                bd.push_back(d);
                bk.push_back(($urandom_range(0, 7) == 0) ? keep_t'(0) : keep_t'($urandom));
            end
            send_stream(w, bd, bk, 2);
        end
        rand_ready = 1'b0;
        drain();
        check_val("stress_words_out", words_out, 32'(exp_words));
    endtask

    initial begin
        rst_n         = 1'b0;
        in_type_valid = 1'b0;
        in_type_data  = 3'd0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_keep       = '0;
        in_last       = 1'b0;
        out_tready    = 1'b1;
        ready_force   = 1'b1;
        rand_ready    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_tvalid", 32'(out_tvalid), 32'd0);
        check_val("reset_tlast", 32'(out_tlast), 32'd0);
        check_wide("reset_tdata", out_tdata, '0);
        check_wide("reset_tkeep", AW'(out_tkeep), '0);
        check_val("reset_words_out", words_out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fork
            monitor_loop();
            ready_loop();
            run_tests();
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
